// File: rtl/lfsr_bank_pkg.sv
// Shared types and constants for lfsr_bank: FSM states, XNOR tap masks and seed sanitising.
package lfsr_bank_pkg;

    typedef enum logic {
        WARM,
        READY
    } state_t;

    // Tap masks (bit index = stage) for maximal-length XNOR Fibonacci LFSRs, W = 3..16.
    function automatic logic [15:0] tap_mask(input int unsigned w);
        logic [15:0] m;
        case (w)
            3:       m = 16'h0006;
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h000C;
        endcase
        return m;
    endfunction

    // All-ones is the XNOR lock-up state, so it is never allowed as a seed.
    function automatic logic [15:0] fix_seed(input logic [15:0] v, input int unsigned w);
        logic [15:0] m;
        m = 16'((17'd1 << w) - 17'd1);
        if ((v & m) == m)
            return '0;
        return v & m;
    endfunction

endpackage

// File: rtl/lfsr_bank_chan.sv
// One XNOR Fibonacci LFSR channel with step, seed load and (LFSR_BANK_LOCKUP_EN) lock-up recovery.
module lfsr_chan
    import lfsr_bank_pkg::*;
#(
    parameter int unsigned      W    = 4,
    parameter logic [W-1:0]     SEED = '0
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state
`ifdef LFSR_BANK_LOCKUP_EN
    ,
    output logic         lockup
`endif
);

    localparam logic [W-1:0] TAPS = W'(tap_mask(W));

    logic [W-1:0] s;
    logic         fb;

    assign fb    = ~^(s & TAPS);
    assign state = s;

`ifdef LFSR_BANK_LOCKUP_EN
    assign lockup = (s == '1);
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            s <= SEED;
        else if (load)
            s <= load_val;
`ifdef LFSR_BANK_LOCKUP_EN
        else if (s == '1)
            s <= SEED;
`endif
        else if (step)
            s <= {s[W-2:0], fb};
    end

endmodule

// File: rtl/lfsr_bank.sv
// Bank of N XNOR LFSRs with warm-up, seed load and Req/Valid sampling.
// Optional sticky lock-up detection enabled by defining LFSR_BANK_LOCKUP_EN.
module lfsr_bank
    import lfsr_bank_pkg::*;
#(
    parameter int unsigned W         = 4,
    parameter int unsigned N         = 4,
    parameter int unsigned SEED_BASE = 0,
    parameter int unsigned WARMUP    = 0
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic [N-1:0]   Step,
    input  logic           SeedLoad,
    input  logic [W-1:0]   SeedData,
    input  logic           Req,
    output logic           Valid,
    output logic [N*W-1:0] Out,
    output logic           Busy,
    output logic           Lockup
);

    localparam state_t     START_STATE = (WARMUP == 0) ? READY : WARM;
    localparam logic [7:0] WARMUP8     = 8'(WARMUP);

    state_t         state;
    logic [7:0]     cnt;
    logic           pending;
    logic [W-1:0]   ch [N];
    logic [N*W-1:0] cat;
`ifdef LFSR_BANK_LOCKUP_EN
    logic [N-1:0]   chan_lock;
    logic           lock_q;
`endif

    genvar i;
    for (i = 0; i < N; i++) begin : g_ch
        localparam logic [W-1:0] SEED_I = W'(fix_seed(16'((SEED_BASE + i) % (1 << W)), W));

        lfsr_chan #(
            .W    (W),
            .SEED (SEED_I)
        ) u_chan (
            .Clk      (Clk),
            .Reset_n  (Reset_n),
            .step     ((state == WARM) || Step[i]),
            .load     (SeedLoad),
            .load_val (W'(fix_seed(16'(SeedData ^ W'(i)), W))),
            .state    (ch[i])
`ifdef LFSR_BANK_LOCKUP_EN
            ,
            .lockup   (chan_lock[i])
`endif
        );
    end

    always_comb begin
        cat = '0;
        for (int unsigned k = 0; k < N; k++)
            cat[(N-1-k)*W +: W] = ch[k];
    end

    assign Busy = (state == WARM);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= START_STATE;
            cnt     <= WARMUP8;
            pending <= 1'b0;
            Valid   <= 1'b0;
            Out     <= '0;
        end else begin
            Valid <= 1'b0;
            if (SeedLoad) begin
                state   <= START_STATE;
                cnt     <= WARMUP8;
                pending <= 1'b0;
            end else begin
                case (state)
                    WARM: begin
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1)
                            state <= READY;
                        if (Req)
                            pending <= 1'b1;
                    end
                    READY: begin
                        // cat holds the pre-step channel values of this cycle
                        if (Req || pending) begin
                            Valid   <= 1'b1;
                            Out     <= cat;
                            pending <= 1'b0;
                        end
                    end
                    default: state <= START_STATE;
                endcase
            end
        end
    end

`ifdef LFSR_BANK_LOCKUP_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            lock_q <= 1'b0;
        else if (|chan_lock)
            lock_q <= 1'b1;
    end
    assign Lockup = lock_q;
`else
    assign Lockup = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_bank.sv
// Self-checking bench for lfsr_bank: two configurations against a behavioural model.
module tb_lfsr_bank;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;

    logic [3:0]  a_step = '0;
    logic        a_sl = 1'b0;
    logic [3:0]  a_sd = '0;
    logic        a_req = 1'b0;
    logic        a_valid, a_busy, a_lock;
    logic [15:0] a_out;

    logic [1:0]  b_step = '0;
    logic        b_sl = 1'b0;
    logic [3:0]  b_sd = '0;
    logic        b_req = 1'b0;
    logic        b_valid, b_busy, b_lock;
    logic [7:0]  b_out;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 Clk = ~Clk;

    lfsr_bank #(.W(4), .N(4), .SEED_BASE(0), .WARMUP(0)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Step(a_step), .SeedLoad(a_sl), .SeedData(a_sd),
        .Req(a_req), .Valid(a_valid), .Out(a_out), .Busy(a_busy), .Lockup(a_lock)
    );

    lfsr_bank #(.W(4), .N(2), .SEED_BASE(5), .WARMUP(8)) dutw (
        .Clk(Clk), .Reset_n(Reset_n), .Step(b_step), .SeedLoad(b_sl), .SeedData(b_sd),
        .Req(b_req), .Valid(b_valid), .Out(b_out), .Busy(b_busy), .Lockup(b_lock)
    );

    // Reference model: sequence rule from the spec, 4-bit XNOR of bits 3 and 2.
    int          a_ch [4];
    bit          a_v, a_lk;
    logic [15:0] a_xo;
    int          b_ch [2];
    int          b_wc;
    bit          b_pend, b_v;
    logic [7:0]  b_xo;

    function automatic int nxt(input int s);
        return ((s << 1) & 15) | ((((s >> 3) ^ (s >> 2)) & 1) ^ 1);
    endfunction

    function automatic int fixs(input int s);
        return (s == 15) ? 0 : s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) a_ch[i] = fixs(i % 16);
        a_v = 0; a_lk = 0; a_xo = '0;
        for (int i = 0; i < 2; i++) b_ch[i] = fixs((5 + i) % 16);
        b_wc = 8; b_pend = 0; b_v = 0; b_xo = '0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 4; i++) if (a_ch[i] == 15) a_lk = 1;
        if (a_sl) begin
            for (int i = 0; i < 4; i++) a_ch[i] = fixs(int'(a_sd) ^ i);
            a_v = 0;
        end else begin
            a_v = a_req;
            if (a_req) a_xo = {4'(a_ch[0]), 4'(a_ch[1]), 4'(a_ch[2]), 4'(a_ch[3])};
            for (int i = 0; i < 4; i++) begin
                if (a_ch[i] == 15) a_ch[i] = i;
                else if (a_step[i]) a_ch[i] = nxt(a_ch[i]);
            end
        end
        if (b_sl) begin
            for (int i = 0; i < 2; i++) b_ch[i] = fixs(int'(b_sd) ^ i);
            b_wc = 8; b_pend = 0; b_v = 0;
        end else if (b_wc > 0) begin
            for (int i = 0; i < 2; i++) b_ch[i] = nxt(b_ch[i]);
            b_wc--;
            if (b_req) b_pend = 1;
            b_v = 0;
        end else begin
            b_v = b_req || b_pend;
            if (b_v) b_xo = {4'(b_ch[0]), 4'(b_ch[1])};
            b_pend = 0;
            for (int i = 0; i < 2; i++) if (b_step[i]) b_ch[i] = nxt(b_ch[i]);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_valid", a_valid, a_v);
        chk("a_out", a_out, a_xo);
        chk("a_busy", a_busy, 0);
        chk("a_lock", a_lock, a_lk);
        chk("b_valid", b_valid, b_v);
        chk("b_out", b_out, b_xo);
        chk("b_busy", b_busy, b_wc > 0);
        chk("b_lock", b_lock, 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    initial begin
        int vcount;
        model_reset();
        #22;
        check_all();
        chk("reset_a_out", a_out, 16'h0000);
        chk("reset_b_busy", b_busy, 1);
        Reset_n = 1'b1;

        // A: sample reset seeds; B: Req on warm cycle 2 is held pending
        a_req = 1; tick();
        chk("a_seeds", a_out, 16'h0123);
        a_req = 0; b_req = 1; tick();
        b_req = 0;
        a_step = 4'b0001;
        for (int i = 0; i < 4; i++) tick();
        a_step = 0; a_req = 1; tick();
        chk("a_ch0_after4", a_out[15:12], 4'hE);
        // B warm-up ends and pending Req is served: run to past the Valid pulse
        a_req = 0;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (b_valid) vcount++; end
        chk("b_pending_served", vcount, 1);

        // Full period on all A channels with continuous sampling
        a_step = 4'b1111; a_req = 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("a_no_ones", a_out[15:12] == 4'hF, 0);
        end
        a_step = 0; tick();
        chk("a_period", a_out, 16'hE123);

        // Asynchronous reset between edges
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_a_valid", a_valid, 0);
        chk("arst_a_out", a_out, 16'h0000);
        chk("arst_a_lock", a_lock, 0);
        chk("arst_b_busy", b_busy, 1);
        #2 Reset_n = 1'b1;
        a_req = 0;

        // B: pending Req then SeedLoad on warm cycle 5 restarts warm-up, no Valid
        tick();
        b_req = 1; tick();
        b_req = 0; tick(); tick();
        b_sl = 1; b_sd = 4'(($urandom));  tick();
        b_sl = 0;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (b_valid) vcount++; end
        chk("b_seedload_drops_pending", vcount, 0);

        // A: all-ones seed substitution and same-cycle Req dropped
        a_sl = 1; a_sd = 4'hF; a_req = 1; tick();
        chk("a_sl_no_valid", a_valid, 0);
        a_sl = 0; tick();
        chk("a_sl_seeds", a_out, 16'h0EDC);
        a_req = 0;

`ifdef LFSR_BANK_LOCKUP_EN
        dut.g_ch[2].u_chan.s = 4'hF;
        a_ch[2] = 15;
        tick();
        chk("lock_set", a_lock, 1);
        a_req = 1; tick();
        chk("lock_reload", a_out[7:4], 4'h2);
        a_req = 0; a_sl = 1; a_sd = 4'h3; tick();
        a_sl = 0; tick();
        chk("lock_sticky", a_lock, 1);
`endif

        // Randomised traffic on both instances
        for (int i = 0; i < 400; i++) begin
            a_step = 4'($urandom); a_req = 1'($urandom); a_sd = 4'($urandom);
            a_sl = ($urandom_range(0, 19) == 0);
            b_step = 2'($urandom); b_req = 1'($urandom); b_sd = 4'($urandom);
            b_sl = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
